// File: rtl/llm_staged.sv
// llm_staged: staged lay-low / attack / deception controller with saturating
// dwell timer, configurable attack depth and a deception budget.
`default_nettype none

module llm_staged #(
  parameter int STAGES          = 2,
  parameter int TIMER_W         = 6,
  parameter int LAY_LOW_TIME    = 20,
  parameter int STAGE_TIME      = 20,
  parameter int LAST_STAGE_TIME = 10,
  parameter int DECEPTION_TIME  = 15,
  parameter int MAX_DECEPTIONS  = 3
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               green,
  input  logic               yellow,
  input  logic               red,
  output logic [3:0]         current_state,
  output logic [2:0]         stage,
  output logic [STAGES-1:0]  attack,
  output logic               deception_out,
  output logic               expansion_out,
  output logic [3:0]         deceptions,
  output logic [TIMER_W-1:0] timer
);

  typedef enum logic [3:0] {
    LAY_LOW   = 4'd0,
    DECEPTION = 4'd1,
    ATTACK    = 4'd2,
    FAIL      = 4'd4,
    EXPANSION = 4'd5
  } state_t;

  // Thresholds are zero-extended to the full timer width so saturation compares correctly.
  localparam logic [TIMER_W-1:0] LL_T   = TIMER_W'(LAY_LOW_TIME);
  localparam logic [TIMER_W-1:0] ST_T   = TIMER_W'(STAGE_TIME);
  localparam logic [TIMER_W-1:0] LAST_T = TIMER_W'(LAST_STAGE_TIME);
  localparam logic [TIMER_W-1:0] DEC_T  = TIMER_W'(DECEPTION_TIME);
  localparam logic [3:0]         MAX_D  = 4'(MAX_DECEPTIONS);
  localparam logic [2:0]         LAST_K = 3'(STAGES - 1);
  localparam logic [STAGES-1:0]  STAGE0 = STAGES'(1);

  state_t               state_r, state_n;
  logic [2:0]           stage_r, stage_n;
  logic [STAGES-1:0]    attack_r, attack_n;
  logic                 dec_r, dec_n;
  logic                 exp_r, exp_n;
  logic [3:0]           decs_r, decs_n;
  logic [TIMER_W-1:0]   timer_r, timer_n;
  logic                 load;
  logic                 green_only;

  assign green_only = green & ~yellow & ~red;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r  <= LAY_LOW;
      stage_r  <= 3'd0;
      attack_r <= '0;
      dec_r    <= 1'b0;
      exp_r    <= 1'b0;
      decs_r   <= 4'd0;
      timer_r  <= TIMER_W'(1);
    end else begin
      state_r  <= state_n;
      stage_r  <= stage_n;
      attack_r <= attack_n;
      dec_r    <= dec_n;
      exp_r    <= exp_n;
      decs_r   <= decs_n;
      timer_r  <= timer_n;
    end
  end

  always_comb begin
    state_n  = state_r;
    stage_n  = stage_r;
    attack_n = attack_r;
    dec_n    = dec_r;
    exp_n    = exp_r;
    decs_n   = decs_r;
    load     = 1'b0;

    case (state_r)
      LAY_LOW: begin
        if (red) begin
          state_n = DECEPTION;
          dec_n   = 1'b1;
          decs_n  = (decs_r == 4'hF) ? decs_r : decs_r + 4'd1;
          load    = 1'b1;
        end else if (timer_r >= LL_T && green_only) begin
          state_n  = ATTACK;
          stage_n  = 3'd0;
          attack_n = STAGE0;
          load     = 1'b1;
        end
      end
      ATTACK: begin
        if (red) begin
          state_n = DECEPTION;
          dec_n   = 1'b1;
          decs_n  = (decs_r == 4'hF) ? decs_r : decs_r + 4'd1;
          load    = 1'b1;
        end else if (yellow) begin
          if (stage_r == 3'd0) begin
            state_n  = LAY_LOW;
            attack_n = '0;
          end else begin
            stage_n  = stage_r - 3'd1;
            attack_n = attack_r & ~(STAGE0 << stage_r);
          end
          load = 1'b1;
        end else if (green_only) begin
          if (stage_r < LAST_K && timer_r >= ST_T) begin
            stage_n  = stage_r + 3'd1;
            attack_n = attack_r | (STAGE0 << (stage_r + 3'd1));
            load     = 1'b1;
          end else if (stage_r == LAST_K && timer_r >= LAST_T) begin
            state_n = EXPANSION;
            exp_n   = 1'b1;
            load    = 1'b1;
          end
        end
      end
      DECEPTION: begin
        if (timer_r >= DEC_T) begin
          if (red || decs_r >= MAX_D) begin
            state_n = FAIL;
          end else begin
            state_n  = LAY_LOW;
            attack_n = '0;
            stage_n  = 3'd0;
            dec_n    = 1'b0;
          end
          load = 1'b1;
        end
      end
      FAIL, EXPANSION: begin
      end
      default: begin
        state_n  = LAY_LOW;
        stage_n  = 3'd0;
        attack_n = '0;
        dec_n    = 1'b0;
        exp_n    = 1'b0;
        decs_n   = 4'd0;
        load     = 1'b1;
      end
    endcase

    if (load)
      timer_n = TIMER_W'(1);
    else if (timer_r == {TIMER_W{1'b1}})
      timer_n = timer_r;
    else
      timer_n = timer_r + TIMER_W'(1);
  end

  assign current_state = state_r;
  assign stage         = stage_r;
  assign attack        = attack_r;
  assign deception_out = dec_r;
  assign expansion_out = exp_r;
  assign deceptions    = decs_r;
  assign timer         = timer_r;

endmodule

`default_nettype wire

// File: tb/tb_llm_staged.sv
// Scoreboard bench for llm_staged: dut 0 uses defaults, dut 1 uses STAGES=4, MAX_DECEPTIONS=2.
`default_nettype none

module tb_llm_staged;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic       rn_a = 1'b1, g_a = 1'b0, y_a = 1'b0, r_a = 1'b0;
  logic       rn_b = 1'b1, g_b = 1'b0, y_b = 1'b0, r_b = 1'b0;
  logic [3:0] cs_a, cs_b, dc_a, dc_b;
  logic [2:0] sg_a, sg_b;
  logic [1:0] at_a;
  logic [3:0] at_b;
  logic       do_a, do_b, eo_a, eo_b;
  logic [5:0] tm_a, tm_b;

  llm_staged dut_a (
    .clock(clock), .reset_n(rn_a), .green(g_a), .yellow(y_a), .red(r_a),
    .current_state(cs_a), .stage(sg_a), .attack(at_a), .deception_out(do_a),
    .expansion_out(eo_a), .deceptions(dc_a), .timer(tm_a)
  );

  llm_staged #(.STAGES(4), .MAX_DECEPTIONS(2)) dut_b (
    .clock(clock), .reset_n(rn_b), .green(g_b), .yellow(y_b), .red(r_b),
    .current_state(cs_b), .stage(sg_b), .attack(at_b), .deception_out(do_b),
    .expansion_out(eo_b), .deceptions(dc_b), .timer(tm_b)
  );

  typedef struct {
    int          cyc;
    int          d;
    string       nm;
    logic [28:0] v;
  } item_t;

  item_t sb[$];
  item_t it;
  int n_cmp = 0;
  int n_err = 0;

  function automatic logic [28:0] pk(input logic [3:0] st, input logic [2:0] stg,
                                     input logic [7:0] att, input logic dout,
                                     input logic eout, input logic [3:0] decs,
                                     input logic [7:0] tmr);
    return {st, stg, att, dout, eout, decs, tmr};
  endfunction

  function automatic logic [28:0] obs(input int d);
    if (d == 0) return pk(cs_a, sg_a, {6'b0, at_a}, do_a, eo_a, dc_a, {2'b0, tm_a});
    return pk(cs_b, sg_b, {4'b0, at_b}, do_b, eo_b, dc_b, {2'b0, tm_b});
  endfunction

  task automatic push(input int cyc, input int d, input string nm, input logic [28:0] v);
    item_t x;
    x.cyc = cyc; x.d = d; x.nm = nm; x.v = v;
    sb.push_back(x);
  endtask

  task automatic set_in(input int d, input logic g, input logic y, input logic r);
    if (d == 0) begin g_a = g; y_a = y; r_a = r; end
    else begin g_b = g; y_b = y; r_b = r; end
  endtask

  // Leaves the selected dut just out of reset at a negedge; the next posedge is cycle 1.
  task automatic do_reset(input int d);
    set_in(d, 1'b0, 1'b0, 1'b0);
    if (d == 0) rn_a = 1'b0; else rn_b = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    if (d == 0) rn_a = 1'b1; else rn_b = 1'b1;
  endtask

  task automatic test_reset;
    #2;
    rn_a = 1'b0; rn_b = 1'b0;
    set_in(0, 1'b1, 1'b0, 1'b0);
    set_in(1, 1'b0, 1'b0, 1'b1);
    push(0, 0, "reset_a", pk(0, 0, 0, 0, 0, 0, 1));
    push(0, 1, "reset_b", pk(0, 0, 0, 0, 0, 0, 1));
    #1;
    while (sb.size() > 0) begin
      it = sb.pop_front(); n_cmp++;
      if (obs(it.d) !== it.v) begin
        n_err++; $display("FAIL %s: got %h expected %h", it.nm, obs(it.d), it.v);
      end
    end
    push(0, 0, "reset_hold_a", pk(0, 0, 0, 0, 0, 0, 1));
    push(0, 1, "reset_hold_b", pk(0, 0, 0, 0, 0, 0, 1));
    @(posedge clock); #1;
    while (sb.size() > 0) begin
      it = sb.pop_front(); n_cmp++;
      if (obs(it.d) !== it.v) begin
        n_err++; $display("FAIL %s: got %h expected %h", it.nm, obs(it.d), it.v);
      end
    end
  endtask

  task automatic test_green_climb;
    do_reset(0);
    push(19,  0, "ll_t20",     pk(0, 0, 0, 0, 0, 0, 20));
    push(20,  0, "attack0",    pk(2, 0, 1, 0, 0, 0, 1));
    push(39,  0, "stage0_t20", pk(2, 0, 1, 0, 0, 0, 20));
    push(40,  0, "stage1",     pk(2, 1, 3, 0, 0, 0, 1));
    push(49,  0, "stage1_t10", pk(2, 1, 3, 0, 0, 0, 10));
    push(50,  0, "expansion",  pk(5, 1, 3, 0, 1, 0, 1));
    push(112, 0, "exp_sat",    pk(5, 1, 3, 0, 1, 0, 63));
    push(120, 0, "exp_hold",   pk(5, 1, 3, 0, 1, 0, 63));
    for (int c = 1; c <= 120; c++) begin
      if (c >= 100) set_in(0, 1'b0, 1'b1, 1'b1);
      else set_in(0, 1'b1, 1'b0, 1'b0);
      @(posedge clock); #1;
      while (sb.size() > 0 && sb[0].cyc == c) begin
        it = sb.pop_front(); n_cmp++;
        if (obs(it.d) !== it.v) begin
          n_err++; $display("FAIL %s: got %h expected %h", it.nm, obs(it.d), it.v);
        end
      end
    end
  endtask

  task automatic test_yellow_retreat;
    do_reset(1);
    push(20, 1, "gy_no_adv",  pk(0, 0, 0, 0, 0, 0, 21));
    push(21, 1, "b_attack0",  pk(2, 0, 1, 0, 0, 0, 1));
    push(61, 1, "b_stage2",   pk(2, 2, 7, 0, 0, 0, 1));
    push(62, 1, "y_stage1",   pk(2, 1, 3, 0, 0, 0, 1));
    push(63, 1, "y_stage0",   pk(2, 0, 1, 0, 0, 0, 1));
    push(64, 1, "y_lay_low",  pk(0, 0, 0, 0, 0, 0, 1));
    push(65, 1, "ll_idle",    pk(0, 0, 0, 0, 0, 0, 2));
    for (int c = 1; c <= 65; c++) begin
      if (c == 20) set_in(1, 1'b1, 1'b1, 1'b0);
      else if (c <= 61) set_in(1, 1'b1, 1'b0, 1'b0);
      else if (c <= 64) set_in(1, 1'b0, 1'b1, 1'b0);
      else set_in(1, 1'b0, 1'b0, 1'b0);
      @(posedge clock); #1;
      while (sb.size() > 0 && sb[0].cyc == c) begin
        it = sb.pop_front(); n_cmp++;
        if (obs(it.d) !== it.v) begin
          n_err++; $display("FAIL %s: got %h expected %h", it.nm, obs(it.d), it.v);
        end
      end
    end
  endtask

  task automatic test_deception_clear;
    do_reset(0);
    push(40, 0, "pre_stage1",  pk(2, 1, 3, 0, 0, 0, 1));
    push(41, 0, "ry_decept",   pk(1, 1, 3, 1, 0, 1, 1));
    push(45, 0, "dec_ignore",  pk(1, 1, 3, 1, 0, 1, 5));
    push(55, 0, "dec_t15",     pk(1, 1, 3, 1, 0, 1, 15));
    push(56, 0, "dec_clear",   pk(0, 0, 0, 0, 0, 1, 1));
    for (int c = 1; c <= 56; c++) begin
      if (c <= 40) set_in(0, 1'b1, 1'b0, 1'b0);
      else if (c == 41) set_in(0, 1'b0, 1'b1, 1'b1);
      else if (c <= 45) set_in(0, 1'b1, 1'b0, 1'b1);
      else if (c <= 55) set_in(0, 1'b1, 1'b0, 1'b0);
      else set_in(0, 1'b0, 1'b0, 1'b0);
      @(posedge clock); #1;
      while (sb.size() > 0 && sb[0].cyc == c) begin
        it = sb.pop_front(); n_cmp++;
        if (obs(it.d) !== it.v) begin
          n_err++; $display("FAIL %s: got %h expected %h", it.nm, obs(it.d), it.v);
        end
      end
    end
  endtask

  task automatic test_deception_fail;
    logic [6:0] cv;
    do_reset(0);
    push(40, 0, "gy_retreat", pk(0, 0, 0, 0, 0, 0, 1));
    push(41, 0, "ll_red",     pk(1, 0, 0, 1, 0, 1, 1));
    push(56, 0, "red_fail",   pk(4, 0, 0, 1, 0, 1, 1));
    push(70, 0, "fail_hold",  pk(4, 0, 0, 1, 0, 1, 15));
    for (int c = 1; c <= 70; c++) begin
      cv = 7'(c);
      if (c <= 39) set_in(0, 1'b1, 1'b0, 1'b0);
      else if (c == 40) set_in(0, 1'b1, 1'b1, 1'b0);
      else if (c <= 56) set_in(0, 1'b0, 1'b0, 1'b1);
      else set_in(0, cv[0], cv[1], cv[2]);
      @(posedge clock); #1;
      while (sb.size() > 0 && sb[0].cyc == c) begin
        it = sb.pop_front(); n_cmp++;
        if (obs(it.d) !== it.v) begin
          n_err++; $display("FAIL %s: got %h expected %h", it.nm, obs(it.d), it.v);
        end
      end
    end
  endtask

  task automatic test_budget;
    do_reset(1);
    push(1,  1, "bud_dec1",  pk(1, 0, 0, 1, 0, 1, 1));
    push(15, 1, "bud_t15",   pk(1, 0, 0, 1, 0, 1, 15));
    push(16, 1, "bud_clr1",  pk(0, 0, 0, 0, 0, 1, 1));
    push(17, 1, "bud_dec2",  pk(1, 0, 0, 1, 0, 2, 1));
    push(32, 1, "bud_fail",  pk(4, 0, 0, 1, 0, 2, 1));
    push(33, 1, "bud_hold",  pk(4, 0, 0, 1, 0, 2, 2));
    for (int c = 1; c <= 33; c++) begin
      set_in(1, 1'b0, 1'b0, (c == 1 || c == 17));
      @(posedge clock); #1;
      while (sb.size() > 0 && sb[0].cyc == c) begin
        it = sb.pop_front(); n_cmp++;
        if (obs(it.d) !== it.v) begin
          n_err++; $display("FAIL %s: got %h expected %h", it.nm, obs(it.d), it.v);
        end
      end
    end
  endtask

  task automatic test_async_reset;
    do_reset(0);
    push(25, 0, "pre_reset", pk(2, 0, 1, 0, 0, 0, 6));
    for (int c = 1; c <= 25; c++) begin
      set_in(0, 1'b1, 1'b0, 1'b0);
      @(posedge clock); #1;
      while (sb.size() > 0 && sb[0].cyc == c) begin
        it = sb.pop_front(); n_cmp++;
        if (obs(it.d) !== it.v) begin
          n_err++; $display("FAIL %s: got %h expected %h", it.nm, obs(it.d), it.v);
        end
      end
    end
    #2;
    rn_a = 1'b0;
    push(0, 0, "async_rst", pk(0, 0, 0, 0, 0, 0, 1));
    #1;
    it = sb.pop_front(); n_cmp++;
    if (obs(it.d) !== it.v) begin
      n_err++; $display("FAIL %s: got %h expected %h", it.nm, obs(it.d), it.v);
    end
    push(0, 0, "rst_held", pk(0, 0, 0, 0, 0, 0, 1));
    @(posedge clock); #1;
    it = sb.pop_front(); n_cmp++;
    if (obs(it.d) !== it.v) begin
      n_err++; $display("FAIL %s: got %h expected %h", it.nm, obs(it.d), it.v);
    end
    rn_a = 1'b1;
  endtask

  initial begin
    test_reset();
    test_green_climb();
    test_yellow_retreat();
    test_deception_clear();
    test_deception_fail();
    test_budget();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/llm_staged.md
# llm_staged

Parametrised successor to the single-path lay-low/attack/deception controller. It is a Moore-style FSM driven by the three threat-level inputs (`green`, `yellow`, `red`) that escalates through `STAGES` configurable attack stages before reaching `EXPANSION`. All dwell times are parameters, and the state timer saturates instead of wrapping. A deception budget sends the block to `FAIL` after `MAX_DECEPTIONS` deception episodes. It sits at the same level as the previous controller and drives the attack, deception and expansion indicators.

## Interface
Parameters:
- `STAGES`, default 2: number of attack stages, legal range 1..8.
- `TIMER_W`, default 6: width of the dwell timer. Must hold the largest time parameter.
- `LAY_LOW_TIME`, default 20: cycles required in `LAY_LOW` before stage 0 can be entered.
- `STAGE_TIME`, default 20: cycles required in stage k before advancing to k+1, for k < `STAGES`-1.
- `LAST_STAGE_TIME`, default 10: cycles required in the last stage before `EXPANSION`.
- `DECEPTION_TIME`, default 15: dwell in `DECEPTION` before it resolves.
- `MAX_DECEPTIONS`, default 3: number of deception entries after which resolution always goes to `FAIL`. Legal range 1..15.

Ports:
- `clock` input 1: rising-edge clock.
- `reset_n` input 1: asynchronous, active-low reset.
- `green`, `yellow`, `red` input 1 each: threat level, sampled on `clock`.
- `current_state` output 4: 0 = `LAY_LOW`, 1 = `DECEPTION`, 2 = `ATTACK`, 4 = `FAIL`, 5 = `EXPANSION`.
- `stage` output 3: current attack stage index. It keeps its value outside `ATTACK`.
- `attack` output `STAGES`: thermometer of stages reached (`attack[i]` = 1 when stage i has been reached).
- `deception_out` output 1: high while in `DECEPTION` or `FAIL`.
- `expansion_out` output 1: high in `EXPANSION`.
- `deceptions` output 4: saturating count of deception entries.
- `timer` output `TIMER_W`: dwell counter.

## Operation
- All outputs are registered.
- Reset values: `current_state` = `LAY_LOW`, `stage` = 0, `attack` = 0, `deception_out` = 0, `expansion_out` = 0, `deceptions` = 0, `timer` = 1.
- Input priority in every non-terminal state is `red` > `yellow` > green-advance.
- "Green-only" means `green` = 1 and `yellow` = 0 and `red` = 0.
- `timer` semantics:
  - Loads 1 on every state or stage change.
  - Otherwise increments by 1 per cycle.
  - Saturates at 2^`TIMER_W`-1 and never wraps.
- `LAY_LOW`:
  - `red` → `DECEPTION`.
  - Else if `timer` ≥ `LAY_LOW_TIME` and green-only → `ATTACK`, with `stage` = 0 and `attack[0]` = 1.
- `ATTACK`, stage k:
  - `red` → `DECEPTION`. `attack` is held.
  - Else `yellow` with k = 0 → `LAY_LOW`, clearing `attack[0]`.
  - Else `yellow` with k > 0 → stage k-1, clearing `attack[k]`.
  - Else if k < `STAGES`-1, `timer` ≥ `STAGE_TIME` and green-only → stage k+1, setting `attack[k+1]`.
  - Else if k = `STAGES`-1, `timer` ≥ `LAST_STAGE_TIME` and green-only → `EXPANSION`. `expansion_out` = 1 and `attack` is held.
- Entering `DECEPTION`:
  - `deception_out` = 1.
  - `deceptions` increments, saturating at 15.
- `DECEPTION`:
  - No input has any effect until `timer` ≥ `DECEPTION_TIME`.
  - At resolution, if `red` = 1 or `deceptions` ≥ `MAX_DECEPTIONS` → `FAIL`. `deception_out` stays 1.
  - Otherwise → `LAY_LOW`. `attack` = 0, `stage` = 0, `deception_out` = 0.
- `FAIL` and `EXPANSION` are terminal:
  - Only `timer` changes (saturating).
  - Only `reset_n` leaves these states.
- An illegal `current_state` encoding → `LAY_LOW`, with `timer` = 1 and all other outputs at their reset values.
- Reset asserted at any time forces the reset values immediately, independent of `clock`.

## Timing
- Transition latency is 1 cycle: the condition is sampled at rising edge N and the new state and outputs are visible after edge N.
- With green-only held from reset release, `ATTACK` is entered on the `LAY_LOW_TIME`-th rising edge (`timer` steps 1..20, then the condition is met at 20).
- Dwell counts are inclusive of the entry cycle, because `timer` = 1 on the entry cycle.
- `reset_n` deassertion is synchronised by the integrator. The block counts the first edge with `reset_n` = 1 as cycle 1.
- Simultaneous inputs:
  - `red` together with `yellow` resolves as `red`.
  - `yellow` together with a satisfied green advance resolves as `yellow`.
  - `green` together with `yellow` is not green-only, so it never advances.
- Timer saturation must not falsely satisfy or unsatisfy a `≥` comparison. Threshold tests use full `TIMER_W` width, and parameters are zero-extended.

## Test plan
- Defaults, green-only held from reset → `ATTACK` stage 0 after edge 20 → stage 1 after a further 20 → `EXPANSION` after a further 10. `attack` = 2'b11, `expansion_out` = 1, `timer` saturates at 63.
- `STAGES` = 4, in stage 2: pulse `yellow` → stage 1 with `attack` = 4'b0011. Pulse `yellow` again → stage 0. Pulse `yellow` a third time → `LAY_LOW` with `attack` = 0.
- In stage 1, `red` asserted together with `yellow` → `DECEPTION`, `deceptions` = 1, `attack` unchanged. `red` low at `timer` 15 → `LAY_LOW`, `attack` = 0, `deception_out` = 0.
- `DECEPTION` with `red` still high at `timer` 15 → `FAIL` with `deception_out` = 1. Further inputs cause no change.
- `MAX_DECEPTIONS` = 2: two `red` episodes each cleared within the deception window. The second resolution goes to `FAIL` even with `red` = 0. `deceptions` = 2.
- Assert `reset_n` low mid-stage, asynchronously between edges → all outputs take reset values immediately. `timer` = 1 and `current_state` = 0.
